// File: rtl/score_counter_bcd_if.sv
// Game-control <-> score block bundle: run/collide/clear/show_hi
// controls in, BCD scores, segments, state and flags out.
interface score_counter_bcd_if #(
  parameter int DIGITS = 2
);
  logic                  run;
  logic                  collide;
  logic                  clear;
  logic                  show_hi;
  logic [4*DIGITS-1:0]   score_bcd;
  logic [4*DIGITS-1:0]   hi_bcd;
  logic [7*DIGITS-1:0]   hex_seg;
  logic [1:0]            state;
  logic                  win;
  logic                  new_hi;

  modport master (
    output run, collide, clear, show_hi,
    input  score_bcd, hi_bcd, hex_seg,
    input  state, win, new_hi
  );

  modport slave (
    input  run, collide, clear, show_hi,
    output score_bcd, hi_bcd, hex_seg,
    output state, win, new_hi
  );
endinterface

// File: rtl/score_counter_bcd.sv
// BCD game score with tick prescaler, target win, high score
// and blanked active-low 7-seg output. Ports: CLOCK_50, KEY, io.
module score_counter_bcd #(
  parameter int TICKS_PER_POINT = 50000000,
  parameter int DIGITS          = 2,
  parameter int TARGET          = 99
) (
  input  logic CLOCK_50,
  input  logic KEY,
  score_counter_bcd_if.slave io
);
  localparam int W  = 4 * DIGITS;
  localparam int SW = 7 * DIGITS;
  localparam int PW = $clog2(TICKS_PER_POINT);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_OVER = 2'b10,
    S_WIN  = 2'b11
  } state_t;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  localparam logic [W-1:0]  TGT_BCD = to_bcd(TARGET);
  localparam logic [PW-1:0] P_LAST  =
    PW'(TICKS_PER_POINT - 1);
  // digit 0 shows "0", higher digits blank
  localparam logic [SW-1:0] HEX_RST = ~SW'(7'b0111111);

  state_t        state_q, state_d;
  logic [W-1:0]  score_q, score_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          new_hi_q, new_hi_d;
  logic [SW-1:0] hex_q, hex_d;

  logic [W-1:0]  inc;
  logic          end_rnd;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    hi_d     = hi_q;
    presc_d  = presc_q;
    new_hi_d = new_hi_q;
    end_rnd  = 1'b0;
    inc      = bcd_inc(score_q);
    unique case (state_q)
      S_IDLE: begin
        score_d  = '0;
        presc_d  = '0;
        new_hi_d = 1'b0;
        if (io.run) state_d = S_RUN;
      end
      S_RUN: begin
        if (io.clear) begin
          state_d  = S_IDLE;
          score_d  = '0;
          presc_d  = '0;
          new_hi_d = 1'b0;
        end else if (io.collide) begin
          state_d = S_OVER;
          end_rnd = 1'b1;
        end else if (io.run) begin
          if (presc_q == P_LAST) begin
            presc_d = '0;
            score_d = inc;
            if (inc == TGT_BCD) begin
              state_d = S_WIN;
              end_rnd = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      S_OVER, S_WIN: begin
        if (io.clear) begin
          state_d  = S_IDLE;
          score_d  = '0;
          presc_d  = '0;
          new_hi_d = 1'b0;
        end
      end
    endcase
    // packed BCD orders the same as its decimal value
    if (end_rnd && (score_d > hi_q)) begin
      hi_d     = score_d;
      new_hi_d = 1'b1;
    end
  end

  always_comb begin
    logic [W-1:0] src;
    logic         nz;
    hex_d = '1;
    src   = io.show_hi ? hi_q : score_q;
    nz    = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (src[4*i +: 4] != 4'd0);
      if (nz || (i == 0))
        hex_d[7*i +: 7] = seg7(src[4*i +: 4]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      state_q  <= S_IDLE;
      score_q  <= '0;
      hi_q     <= '0;
      presc_q  <= '0;
      new_hi_q <= 1'b0;
      hex_q    <= HEX_RST;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      hi_q     <= hi_d;
      presc_q  <= presc_d;
      new_hi_q <= new_hi_d;
      hex_q    <= hex_d;
    end
  end

  assign io.score_bcd = score_q;
  assign io.hi_bcd    = hi_q;
  assign io.hex_seg   = hex_q;
  assign io.state     = state_q;
  assign io.win       = (state_q == S_WIN);
  assign io.new_hi    = new_hi_q;
endmodule

// File: tb/tb_score_counter_bcd.sv
// Randomised + directed bench for score_counter_bcd against a
// decimal-integer reference model of the scoring rules.
module tb_score_counter_bcd;
  localparam int T   = 4;
  localparam int TGT = 12;

  logic clk;
  logic key;
  int   n_chk;
  int   n_err;

  score_counter_bcd_if #(.DIGITS(2)) bus ();

  score_counter_bcd #(
    .TICKS_PER_POINT(T),
    .DIGITS(2),
    .TARGET(TGT)
  ) dut (
    .CLOCK_50(clk),
    .KEY(key),
    .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000
  };

  // model: 0 idle, 1 run, 2 over, 3 win; m_p = run cycles
  // since the last point
  int          m_st;
  int          m_sc;
  int          m_hi;
  int          m_p;
  bit          m_nh;
  logic [13:0] m_hex;

  function automatic logic [7:0] bcd(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [13:0] disp(input int v);
    logic [6:0] s1;
    s1 = (v / 10 == 0) ? 7'h7f : seg_tab[(v / 10) % 10];
    return {s1, seg_tab[v % 10]};
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("score", 32'(bus.score_bcd), 32'(bcd(m_sc)));
    check("hi", 32'(bus.hi_bcd), 32'(bcd(m_hi)));
    check("state", 32'(bus.state), 32'(m_st));
    check("win", 32'(bus.win), 32'(m_st == 3));
    check("new_hi", 32'(bus.new_hi), 32'(m_nh));
    check("hex", 32'(bus.hex_seg), 32'(m_hex));
  endtask

  task automatic end_round();
    if (m_sc > m_hi) begin
      m_hi = m_sc;
      m_nh = 1'b1;
    end
  endtask

  task automatic to_idle();
    m_st = 0;
    m_sc = 0;
    m_p  = 0;
    m_nh = 1'b0;
  endtask

  task automatic model_reset();
    to_idle();
    m_hi  = 0;
    m_hex = {7'h7f, seg_tab[0]};
  endtask

  task automatic model_step(input bit r, co, cl, sh);
    m_hex = disp(sh ? m_hi : m_sc);
    case (m_st)
      0: if (r) m_st = 1;
      1: begin
        if (cl) to_idle();
        else if (co) begin
          m_st = 2;
          end_round();
        end else if (r) begin
          m_p++;
          if (m_p == T) begin
            m_p = 0;
            m_sc++;
            if (m_sc == TGT) begin
              m_st = 3;
              end_round();
            end
          end
        end
      end
      default: if (cl) to_idle();
    endcase
  endtask

  task automatic step(input bit r, co, cl, sh);
    bus.run     = r;
    bus.collide = co;
    bus.clear   = cl;
    bus.show_hi = sh;
    @(posedge clk);
    #1;
    model_step(r, co, cl, sh);
    compare_all();
  endtask

  // called at posedge+1; reset lands mid-cycle
  task automatic do_reset();
    bus.run     = 1'b0;
    bus.collide = 1'b0;
    bus.clear   = 1'b0;
    bus.show_hi = 1'b0;
    #2;
    key = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    key = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    key = 1'b1;
    bus.run     = 1'b0;
    bus.collide = 1'b0;
    bus.clear   = 1'b0;
    bus.show_hi = 1'b0;
    #1;
    key = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    key = 1'b1;

    // first point T cycles after RUN entry
    step(1, 0, 0, 0);
    for (int k = 0; k < T; k++) step(1, 0, 0, 0);
    check("first_pt", 32'(bus.score_bcd), 32'h01);

    // run to target, then run is ignored
    for (int k = 0; k < 200 && m_st != 3; k++)
      step(1, 0, 0, 0);
    check("win_state", 32'(bus.state), 32'h3);
    check("win_hi", 32'(bus.hi_bcd), 32'h12);
    for (int k = 0; k < 6; k++) step(1, 0, 0, 0);
    check("win_hold", 32'(bus.score_bcd), 32'h12);

    // replay, collide at 07, show high score
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 200 && m_sc != 7; k++)
      step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("over_sc", 32'(bus.score_bcd), 32'h07);
    check("over_nh", 32'(bus.new_hi), 32'h0);
    step(0, 0, 0, 1);
    check("show_hi",
          32'(bus.hex_seg), {18'h0, 7'b1111001, 7'b0100100});

    // pause mid-count for 10 cycles
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    for (int k = 0; k < 200 && !(m_sc == 2 && m_p == 1); k++)
      step(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0);
    for (int k = 0; k < T - 2; k++) step(1, 0, 0, 0);
    check("pause_pre", 32'(bus.score_bcd), 32'h02);
    step(1, 0, 0, 0);
    check("pause_pt", 32'(bus.score_bcd), 32'h03);

    // collide on the tick cycle at 11
    for (int k = 0; k < 200 && !(m_sc == 11 && m_p == T - 1); k++)
      step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("tick_col_sc", 32'(bus.score_bcd), 32'h11);
    check("tick_col_st", 32'(bus.state), 32'h2);

    // clear and collide together
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    check("clr_col", 32'(bus.state), 32'h0);

    // async reset at 05 with hi 12
    step(1, 0, 0, 0);
    for (int k = 0; k < 200 && m_sc != 5; k++)
      step(1, 0, 0, 0);
    check("pre_rst", 32'(bus.score_bcd), 32'h05);
    do_reset();
    step(0, 0, 0, 0);
    check("post_rst_hex",
          32'(bus.hex_seg), {18'h0, 7'b1111111, 7'b1000000});

    // random play
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
